branch_pc_ctrl: RTL and testbench

- Next-PC stage directly downstream of the branch comparator.
- Consumes BrEq/BrLt and drives the comparator's unsigned-select from funct3.
- Resolves conditional branches, JAL and JALR; owns the architectural PC register; stalls on instruction-memory readiness.
- Traps misaligned targets and keeps saturating branch/taken performance counters.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/branch_pc_ctrl_if.sv | 45 ++++
 rtl/branch_taken_dec.sv | 27 ++
 rtl/branch_pc_ctrl.sv | 128 ++++++++++++
 tb/tb_branch_pc_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the next-PC stage: branch funct3 codes, PC FSM states, default vectors.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/branch_pc_ctrl_if.sv
// Bundle between the decode/comparator side and the next-PC stage.
// Latency: none (wires only).
// Backpressure: imem_ready from the fetch side stalls the PC owner.
interface branch_pc_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) ();

    logic             imem_ready;
    logic             branch;
    logic             jal;
    logic             jalr;
    logic [2:0]       funct3;
    logic             BrEq;
    logic             BrLt;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1;
    logic             trap_ack;
    logic             clr_cnt;

    logic             br_unsign;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus4;
    logic             fetch_req;
    logic             taken;
    logic             misalign_trap;
    logic [XLEN-1:0]  trap_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] br_taken_count;

    // Core side: presents the instruction and comparator results, observes the PC.
    modport master (
        output imem_ready, branch, jal, jalr, funct3, BrEq, BrLt, imm, rs1, trap_ack, clr_cnt,
        input  br_unsign, pc, pc_plus4, fetch_req, taken, misalign_trap, trap_pc,
               br_count, br_taken_count
    );

    // PC stage side.
    modport slave (
        input  imem_ready, branch, jal, jalr, funct3, BrEq, BrLt, imm, rs1, trap_ack, clr_cnt,
        output br_unsign, pc, pc_plus4, fetch_req, taken, misalign_trap, trap_pc,
               br_count, br_taken_count
    );

endinterface

// File: rtl/branch_taken_dec.sv
// Decodes funct3 with comparator flags into branch condition and legality.
// Latency: combinational.
// Backpressure: none.
module branch_taken_dec
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       br_eq,
    input  logic       br_lt,
    output logic       cond,
    output logic       legal
);

    // Unsigned variants share the same flag; the comparator already applied signedness.
    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            F3_BEQ:           cond = br_eq;
            F3_BNE:           cond = !br_eq;
            F3_BLT, F3_BLTU:  cond = br_lt;
            F3_BGE, F3_BGEU:  cond = !br_lt;
            default:          legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_ctrl.sv
// Next-PC stage: resolves branches/JAL/JALR, owns the PC, traps misaligned targets, counts branches.
// Latency: PC updates one cycle after an advancing RUN cycle; taken/br_unsign are combinational.
// Backpressure: imem_ready = 0 freezes PC and counters; TRAP state ignores control inputs until trap_ack.
module branch_pc_ctrl
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEF_TRAP_VEC),
    parameter int              CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_pc_ctrl_if.slave       bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [XLEN-1:0]  BIT0_CLR = ~XLEN'(1);

    pc_state_e         state;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   trap_pc_q;
    logic              fetch_req_q;
    logic              misalign_q;
    logic [CNT_W-1:0]  br_cnt_q;
    logic [CNT_W-1:0]  br_taken_cnt_q;

    logic              cond;
    logic              legal;
    logic [XLEN-1:0]   jalr_sum;
    logic [XLEN-1:0]   target;
    logic              taken;
    logic              advance;
    logic              misalign;
    logic              count_en;

    branch_taken_dec u_dec (
        .funct3 (bus.funct3),
        .br_eq  (bus.BrEq),
        .br_lt  (bus.BrLt),
        .cond   (cond),
        .legal  (legal)
    );

    assign pc_plus4 = pc_q + XLEN'(4);
    assign jalr_sum = bus.rs1 + bus.imm;

    // Target selection and control-transfer qualification; jalr beats jal beats branch.
    always_comb begin
        target   = bus.jalr ? (jalr_sum & BIT0_CLR) : (pc_q + bus.imm);
        taken    = (state == RUN) && (bus.jalr || bus.jal || (bus.branch && legal && cond));
        advance  = (state == RUN) && bus.imem_ready;
        misalign = advance && taken && target[1];
        count_en = advance && bus.branch && !bus.jal && !bus.jalr && legal && !misalign;
    end

    // PC state machine: one BOOT cycle, then run until a misaligned taken target parks us in TRAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc_q        <= RESET_PC;
            fetch_req_q <= 1'b0;
            misalign_q  <= 1'b0;
            trap_pc_q   <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_req_q <= 1'b1;
                end
                RUN: begin
                    if (advance) begin
                        if (misalign) begin
                            state       <= TRAP;
                            fetch_req_q <= 1'b0;
                            misalign_q  <= 1'b1;
                            trap_pc_q   <= target;
                        end else begin
                            pc_q <= taken ? target : pc_plus4;
                        end
                    end
                end
                TRAP: begin
                    if (bus.trap_ack) begin
                        state       <= RUN;
                        fetch_req_q <= 1'b1;
                        misalign_q  <= 1'b0;
                        pc_q        <= TRAP_VEC;
                    end
                end
                default: begin
                    state       <= BOOT;
                    fetch_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating retired-branch counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q       <= '0;
            br_taken_cnt_q <= '0;
        end else if (bus.clr_cnt) begin
            br_cnt_q       <= '0;
            br_taken_cnt_q <= '0;
        end else if (count_en) begin
            if (br_cnt_q != CNT_MAX) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (cond && (br_taken_cnt_q != CNT_MAX)) begin
                br_taken_cnt_q <= br_taken_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.br_unsign      = bus.funct3[1];
    assign bus.pc             = pc_q;
    assign bus.pc_plus4       = pc_plus4;
    assign bus.fetch_req      = fetch_req_q;
    assign bus.taken          = taken;
    assign bus.misalign_trap  = misalign_q;
    assign bus.trap_pc        = trap_pc_q;
    assign bus.br_count       = br_cnt_q;
    assign bus.br_taken_count = br_taken_cnt_q;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Self-checking bench for branch_pc_ctrl with a behavioural next-PC model.
// Latency: model advances once per clock edge alongside the DUT.
// Backpressure: imem_ready is randomised to exercise stalls.
module tb_branch_pc_ctrl;
    import riscv_pkg::*;

    localparam int          XLEN  = 32;
    localparam int          CNT_W = 4;
    localparam int          CMAX  = 15;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] TVEC  = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    branch_pc_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_pc_ctrl #(
        .XLEN(XLEN), .RESET_PC(RPC), .TRAP_VEC(TVEC), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Model: 0 = booting, 1 = running, 2 = waiting for trap acknowledge.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_trap_pc;
    bit          m_trap;
    int          m_brc;
    int          m_brt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_cond(input logic [2:0] f, input logic eq, input logic lt,
                                     output bit c, output bit lg);
        lg = 1'b1;
        c  = 1'b0;
        case (f)
            3'd0: c = eq;
            3'd1: c = !eq;
            3'd4, 3'd6: c = lt;
            3'd5, 3'd7: c = !lt;
            default: lg = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target();
        logic [31:0] s;
        if (bus.jalr) begin
            s = bus.rs1 + bus.imm;
            s[0] = 1'b0;
            return s;
        end
        return m_pc + bus.imm;
    endfunction

    function automatic bit ref_taken();
        bit c, lg;
        ref_cond(bus.funct3, bus.BrEq, bus.BrLt, c, lg);
        return (m_mode == 1) && (bus.jalr || bus.jal || (bus.branch && lg && c));
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pc = RPC; m_trap_pc = 0; m_trap = 0; m_brc = 0; m_brt = 0;
    endtask

    task automatic set_idle();
        bus.imem_ready = 1'b1; bus.branch = 0; bus.jal = 0; bus.jalr = 0;
        bus.funct3 = 3'd0; bus.BrEq = 0; bus.BrLt = 0; bus.imm = 0; bus.rs1 = 0;
        bus.trap_ack = 0; bus.clr_cnt = 0;
    endtask

    // Compare every DUT output against the model for the current inputs.
    task automatic check_model();
        chk("pc",        64'(bus.pc),             64'(m_pc));
        chk("pc_plus4",  64'(bus.pc_plus4),       64'(m_pc + 32'd4));
        chk("fetch_req", 64'(bus.fetch_req),      64'(m_mode == 1));
        chk("taken",     64'(bus.taken),          64'(ref_taken()));
        chk("br_unsign", 64'(bus.br_unsign),      64'(bus.funct3[1]));
        chk("misalign",  64'(bus.misalign_trap),  64'(m_trap));
        chk("trap_pc",   64'(bus.trap_pc),        64'(m_trap_pc));
        chk("br_count",  64'(bus.br_count),       64'(m_brc));
        chk("br_taken",  64'(bus.br_taken_count), 64'(m_brt));
    endtask

    task automatic settle();
        #3;
        check_model();
    endtask

    // Advance one clock and move the model by the rules for the inputs held across the edge.
    task automatic tick();
        bit c, lg, tk, inc_b, inc_t;
        logic [31:0] tgt;
        @(posedge clk);
        inc_b = 0; inc_t = 0;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (bus.imem_ready) begin
                    ref_cond(bus.funct3, bus.BrEq, bus.BrLt, c, lg);
                    tk  = bus.jalr || bus.jal || (bus.branch && lg && c);
                    tgt = ref_target();
                    if (tk && tgt[1]) begin
                        m_trap = 1; m_trap_pc = tgt; m_mode = 2;
                    end else begin
                        if (bus.branch && !bus.jal && !bus.jalr && lg) begin
                            inc_b = 1; inc_t = c;
                        end
                        m_pc = tk ? tgt : m_pc + 32'd4;
                    end
                end
            end else if (bus.trap_ack) begin
                m_pc = TVEC; m_trap = 0; m_mode = 1;
            end
            if (bus.clr_cnt) begin
                m_brc = 0; m_brt = 0;
            end else begin
                if (inc_b && m_brc < CMAX) m_brc++;
                if (inc_t && m_brt < CMAX) m_brt++;
            end
        end
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    initial begin
        model_reset();
        set_idle();
        settle();
        chk("reset_pc", 64'(bus.pc), 64'(RPC));
        chk("reset_fetch", 64'(bus.fetch_req), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // BOOT cycle then sequential fetch.
        settle();
        chk("boot_fetch", 64'(bus.fetch_req), 64'd0);
        tick();
        chk("run_pc0", 64'(bus.pc), 64'h0);
        chk("run_fetch", 64'(bus.fetch_req), 64'd1);
        step(); chk("run_pc4", 64'(bus.pc), 64'h4);
        step(); chk("run_pc8", 64'(bus.pc), 64'h8);

        // Jump to 0x40, then BEQ taken.
        bus.jal = 1; bus.imm = 32'h38; step(); set_idle();
        chk("jal_pc40", 64'(bus.pc), 64'h40);
        bus.branch = 1; bus.funct3 = F3_BEQ; bus.BrEq = 1; bus.imm = 32'h10; step(); set_idle();
        chk("beq_pc", 64'(bus.pc), 64'h50);
        chk("beq_cnt", 64'(bus.br_count), 64'd1);
        chk("beq_tcnt", 64'(bus.br_taken_count), 64'd1);

        // BGEU with BrLt set: unsigned compare, not taken.
        bus.branch = 1; bus.funct3 = F3_BGEU; bus.BrLt = 1; bus.imm = 32'h10;
        settle();
        chk("bgeu_unsign", 64'(bus.br_unsign), 64'd1);
        chk("bgeu_taken", 64'(bus.taken), 64'd0);
        tick(); set_idle();
        chk("bgeu_pc", 64'(bus.pc), 64'h54);
        chk("bgeu_cnt", 64'(bus.br_count), 64'd2);
        chk("bgeu_tcnt", 64'(bus.br_taken_count), 64'd1);

        // JALR clears bit 0 of rs1 + imm.
        bus.jalr = 1; bus.rs1 = 32'h1001; bus.imm = 32'h4;
        settle();
        chk("jalr_taken", 64'(bus.taken), 64'd1);
        tick(); set_idle();
        chk("jalr_pc", 64'(bus.pc), 64'h1004);
        chk("jalr_cnt", 64'(bus.br_count), 64'd2);

        // Misaligned JAL from 0x100.
        bus.jal = 1; bus.imm = 32'h100 - 32'h1004; step(); set_idle();
        chk("jal_pc100", 64'(bus.pc), 64'h100);
        bus.jal = 1; bus.imm = 32'h6; step(); set_idle();
        chk("trap_flag", 64'(bus.misalign_trap), 64'd1);
        chk("trap_pc106", 64'(bus.trap_pc), 64'h106);
        chk("trap_pc_hold", 64'(bus.pc), 64'h100);
        chk("trap_fetch", 64'(bus.fetch_req), 64'd0);
        for (int i = 0; i < 3; i++) begin
            bus.branch = 1; bus.jal = 1; bus.imm = 32'h40; step();
        end
        set_idle();
        bus.trap_ack = 1; step(); set_idle();
        chk("ack_pc", 64'(bus.pc), 64'(TVEC));
        chk("ack_flag", 64'(bus.misalign_trap), 64'd0);
        chk("ack_fetch", 64'(bus.fetch_req), 64'd1);

        // Stalled taken BNE: frozen for 4 cycles, then exactly one update.
        bus.branch = 1; bus.funct3 = F3_BNE; bus.BrEq = 0; bus.imm = 32'h20; bus.imem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("stall_taken", 64'(bus.taken), 64'd1);
            tick();
            chk("stall_pc", 64'(bus.pc), 64'h100);
            chk("stall_cnt", 64'(bus.br_count), 64'd2);
        end
        bus.imem_ready = 1; step(); set_idle();
        chk("unstall_pc", 64'(bus.pc), 64'h120);
        chk("unstall_cnt", 64'(bus.br_count), 64'd3);
        chk("unstall_tcnt", 64'(bus.br_taken_count), 64'd2);

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            bus.imem_ready = ($urandom_range(0, 3) != 0);
            bus.branch     = $urandom_range(0, 1);
            bus.jal        = ($urandom_range(0, 5) == 0);
            bus.jalr       = ($urandom_range(0, 7) == 0);
            bus.funct3     = 3'($urandom);
            bus.BrEq       = $urandom_range(0, 1);
            bus.BrLt       = $urandom_range(0, 1);
            bus.imm        = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h2) : ($urandom & 32'hFFFF_FFFC);
            bus.rs1        = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            bus.trap_ack   = ($urandom_range(0, 3) == 0);
            bus.clr_cnt    = ($urandom_range(0, 63) == 0);
            step();
        end
        set_idle();

        // Leave TRAP if random traffic ended there.
        for (int i = 0; i < 3 && m_mode != 1; i++) begin
            bus.trap_ack = 1; step();
        end
        set_idle();
        chk("pre_sat_run", 64'(bus.fetch_req), 64'd1);

        // Saturation with 20 taken branches.
        bus.branch = 1; bus.funct3 = F3_BEQ; bus.BrEq = 1; bus.imm = 32'h4;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt", 64'(bus.br_count), 64'hF);
        chk("sat_tcnt", 64'(bus.br_taken_count), 64'hF);
        bus.clr_cnt = 1; step(); set_idle();
        chk("clr_cnt", 64'(bus.br_count), 64'd0);
        chk("clr_tcnt", 64'(bus.br_taken_count), 64'd0);

        // Enter TRAP, then asynchronous reset mid-cycle.
        bus.jal = 1; bus.imm = 32'h2; step(); set_idle();
        chk("trap2_flag", 64'(bus.misalign_trap), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", 64'(bus.pc), 64'(RPC));
        chk("arst_flag", 64'(bus.misalign_trap), 64'd0);
        chk("arst_fetch", 64'(bus.fetch_req), 64'd0);
        chk("arst_trap_pc", 64'(bus.trap_pc), 64'd0);
        model_reset();
        check_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        step();
        chk("post_rst_pc", 64'(bus.pc), 64'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
